serial_compare_unit: RTL and testbench
======================================

SERIAL_COMPARE_UNIT -- requirements
Module: serial_compare_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits compared per cycle; WIDTH mod CHUNK == 0 (elaboration error otherwise).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port a  input  WIDTH  left operand.
REQ-008 SHALL have port b  input  WIDTH  right operand.
REQ-009 SHALL have port is_signed  input  1  1 = two's-complement compare (SLT), 0 = unsigned (SLTU).
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port lt  output  1  a < b under selected mode.
REQ-013 SHALL have port eq  output  1  a == b.
REQ-014 SHALL have port result  output  WIDTH  {WIDTH-1 zeros, lt}, the RISC-V SLT/SLTU writeback value.
REQ-015 SHALL have port busy_cycles  output  $clog2(NCHUNK)+1  number of chunks examined for current result (NCHUNK = WIDTH/CHUNK).

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; a request is accepted on a clock edge where in_valid && in_ready.
REQ-018 SHALL register a, b and is_signed on acceptance; later input changes have no effect on that request.
REQ-019 SHALL, in signed mode, invert bit WIDTH-1 of both captured operands, then compare unsigned.
REQ-020 SHALL in BUSY compare one CHUNK-bit slice per cycle, MSB slice first (index NCHUNK-1 down to 0).
REQ-021 SHALL, on the first unequal slice, set lt = (slice_a < slice_b), eq=0, and go to DONE (early exit).
REQ-022 SHALL, when slice 0 compares equal, set lt=0, eq=1, and go to DONE.
REQ-023 SHALL make out_valid rise exactly k cycles after the accepting edge, k = slices examined (1..NCHUNK).
REQ-024 SHALL in DONE hold out_valid=1 and lt, eq, result, busy_cycles stable until out_valid && out_ready, then go to IDLE.
REQ-025 SHALL not accept a new request in the cycle a result is consumed (in_ready rises the following cycle).
REQ-026 SHALL keep lt and eq mutually exclusive; gt is implied by !lt && !eq.

Reset
REQ-027 SHALL on rst asynchronously force IDLE, in_ready=1, out_valid=0, lt=0, eq=0, result=0, busy_cycles=0.
REQ-028 SHALL, on rst asserted in BUSY or DONE, discard the in-flight request without producing out_valid.

Structure
REQ-029 SHALL place the state enum and an NCHUNK/width helper function in shared package cmp_pkg.
REQ-030 SHALL instantiate one combinational sub-module cmp_chunk (CHUNK-bit unsigned lt/eq) for the slice compare.

Verification (WIDTH=32, CHUNK=8)
REQ-031 SHALL cover unsigned a=00000001, b=FFFFFFFF -> lt=1, result=00000001, busy_cycles=1, out_valid 1 cycle after accept.
REQ-032 SHALL cover signed a=00000001, b=FFFFFFFF -> lt=0, eq=0, result=0, busy_cycles=1.
REQ-033 SHALL cover unsigned a=7FFFFFFE, b=7FFFFFFF -> lt=1, busy_cycles=4; and a=b=80000000 in both modes -> eq=1, lt=0, busy_cycles=4.
REQ-034 SHALL cover out_ready held low 3 cycles in DONE -> outputs stable, in_ready=0; consumed on 4th cycle, in_ready=1 next cycle.
REQ-035 SHALL cover rst pulsed mid-BUSY (a=00000000, b=00000001) -> out_valid never rises, in_ready=1 immediately, next request completes correctly.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the serial comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } cmp_state_e;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Width needed to count from 0 up to and including num_chunks.
  function automatic int count_width(input int width, input int chunk);
    return $clog2(width / chunk) + 1;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o
);

  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/serial_compare_unit.sv
// Multi-cycle SLT/SLTU comparator: walks operand slices MSB-first and stops
// at the first slice that differs.
module serial_compare_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  input  logic                                 is_signed,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 lt,
  output logic                                 eq,
  output logic [WIDTH-1:0]                     result,
  output logic [count_width(WIDTH, CHUNK)-1:0] busy_cycles
);

  localparam int NCHUNK = num_chunks(WIDTH, CHUNK);
  localparam int CW     = count_width(WIDTH, CHUNK);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : gBadChunk
      $error("serial_compare_unit: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lt_q, lt_d, eq_q, eq_d;
  logic [WIDTH-1:0] signMask;
  logic [CHUNK-1:0] sliceA, sliceB;
  logic             sliceLt, sliceEq;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign signMask = WIDTH'(is_signed) << (WIDTH - 1);

  always_comb begin
    sliceA = a_q[int'(idx_q)*CHUNK +: CHUNK];
    sliceB = b_q[int'(idx_q)*CHUNK +: CHUNK];
  end

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i  (sliceA),
    .b_i  (sliceB),
    .lt_o (sliceLt),
    .eq_o (sliceEq)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a ^ signMask;
          b_d     = b ^ signMask;
          idx_d   = IW'(NCHUNK - 1);
          cnt_d   = '0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (!sliceEq) begin
          lt_d    = sliceLt;
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (idx_q == '0) begin
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign lt          = lt_q;
  assign eq          = eq_q;
  assign result      = WIDTH'(lt_q);
  assign busy_cycles = cnt_q;

endmodule

// File: tb/tb_serial_compare_unit.sv
// Randomised self-checking bench for serial_compare_unit (WIDTH=32, CHUNK=8)
// against a plain-arithmetic reference model.
module tb_serial_compare_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic        lt;
  logic        eq;
  logic [31:0] result;
  logic [2:0]  busy_cycles;

  typedef struct {
    logic expLt;
    logic expEq;
    int   k;
    int   acceptCyc;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic firstSeen = 1'b0;
  logic expectIdleNext = 1'b0;

  serial_compare_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .lt          (lt),
    .eq          (eq),
    .result      (result),
    .busy_cycles (busy_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %08h expected %08h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference: ordering from integer compare; slices examined from the
  // highest differing bit (all four when the operands are equal).
  function automatic void refModel(input logic [31:0] x, input logic [31:0] y, input logic s,
                                   output logic mLt, output logic mEq, output int mK);
    logic found;
    mEq   = (x == y);
    mLt   = s ? ($signed(x) < $signed(y)) : (x < y);
    mK    = 4;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && (x[i] != y[i])) begin
        found = 1'b1;
        mK    = 4 - i / 8;
      end
    end
  endfunction

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got no response expected handshake within 20 cycles", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Drives one request at a negedge, holds out_ready low for holdLow DONE
  // cycles, and returns at the negedge after the result is consumed.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                               input logic eLt, input logic eEq, input int eK, input int holdLow);
    int guard;
    a         = ta;
    b         = tb;
    is_signed = ts;
    in_valid  = 1'b1;
    out_ready = (holdLow == 0);
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) timeoutFail("acceptTimeout");
    expQ.push_back('{expLt: eLt, expEq: eEq, k: eK, acceptCyc: cyc + 1});
    @(negedge clk);
    in_valid  = 1'b0;
    a         = $urandom;
    b         = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) timeoutFail("resultTimeout");
    if (holdLow > 0) begin
      repeat (holdLow) @(negedge clk);
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Compare process: samples just after each negedge, once inputs settle.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL spuriousValid: got out_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          cur = expQ[0];
          checkOutput("lt", 32'(lt), 32'(cur.expLt));
          checkOutput("eq", 32'(eq), 32'(cur.expEq));
          checkOutput("result", result, 32'(cur.expLt));
          checkOutput("busyCycles", 32'(busy_cycles), 32'(cur.k));
          checkOutput("inReadyDone", 32'(in_ready), 32'd0);
          if (!firstSeen) begin
            checkOutput("latency", 32'(cyc - cur.acceptCyc), 32'(cur.k));
            firstSeen = 1'b1;
          end
          if (out_ready) begin
            void'(expQ.pop_front());
            firstSeen      = 1'b0;
            expectIdleNext = 1'b1;
          end
        end
      end else if (expectIdleNext) begin
        checkOutput("inReadyAfter", 32'(in_ready), 32'd1);
        expectIdleNext = 1'b0;
      end else if (expQ.size() > 0 && cyc >= expQ[0].acceptCyc) begin
        checkOutput("inReadyBusy", 32'(in_ready), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs, mLt, mEq;
    int          mK;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    out_ready = 1'b0;
    #3;
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstLt", 32'(lt), 32'd0);
    checkOutput("rstEq", 32'(eq), 32'd0);
    checkOutput("rstResult", result, 32'd0);
    checkOutput("rstBusyCycles", 32'(busy_cycles), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Hand-computed cases.
    applyStimulus(32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1, 0);
    applyStimulus(32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1, 0);
    applyStimulus(32'h7FFFFFFE, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 4, 1);
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 4, 0);
    applyStimulus(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, 4, 2);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b0, 1, 3);
    applyStimulus(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1, 0);
    applyStimulus(32'h12345678, 32'h12345600, 1'b0, 1'b0, 1'b0, 4, 0);
    applyStimulus(32'h12340000, 32'h12350000, 1'b0, 1'b1, 1'b0, 2, 1);

    // Reset in the middle of a four-slice compare.
    a         = 32'h00000000;
    b         = 32'h00000001;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstInReady", 32'(in_ready), 32'd1);
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstBusyCycles", 32'(busy_cycles), 32'd0);
    checkOutput("midRstLt", 32'(lt), 32'd0);
    checkOutput("midRstEq", 32'(eq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    applyStimulus(32'h00000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 4, 0);

    for (int n = 0; n < 150; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = ra;
        2:       rb = ra ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
        default: rb = ra ^ (32'h1 << $urandom_range(0, 31));
      endcase
      rs = 1'($urandom_range(0, 1));
      refModel(ra, rb, rs, mLt, mEq, mK);
      applyStimulus(ra, rb, rs, mLt, mEq, mK, int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
